upsample_2x: RTL and testbench
==============================

# upsample_2x

Nearest-neighbour 2x upsampler for the channel-interleaved pixel streams used between CNN layers in the depth-estimation pipeline. It is the decoder-side counterpart of the max-pool blocks. Each input line of `STRING_LEN` pixels × `CHANNEL_NUM` channels is captured into a line buffer. The line is then emitted twice, and within each emitted line every pixel's channel group appears twice. The result doubles both the width and the height of the feature map. A `ready_o` handshake throttles the upstream stage, because the block produces four output samples per input sample.

## Interface
- `DATA_WIDTH`, 8: sample width in bits.
- `CHANNEL_NUM`, 3: channels per pixel; samples arrive channel 0 first.
- `STRING_LEN`, 4: input pixels per line. The line buffer depth is `CHANNEL_NUM*STRING_LEN` words.

- `clk`  in  1  the single clock for all logic.
- `reset`  in  1  asynchronous reset, active-high.
- `valid_i`  in  1  input sample strobe; a sample is accepted only when `valid_i && ready_o`.
- `data_i`  in  DATA_WIDTH  input sample.
- `sop_i`  in  1  marks the first sample of an input line.
- `eop_i`  in  1  marks the last sample of an input line.
- `sof_i`  in  1  marks the first sample of a frame.
- `eof_i`  in  1  marks the last sample of a frame.
- `ready_o`  out  1  high when the block accepts input.
- `data_o`  out  DATA_WIDTH  output sample.
- `data_valid_o`  out  1  output sample strobe.
- `sop_o`  out  1  first sample of each output line.
- `eop_o`  out  1  last sample of each output line.
- `sof_o`  out  1  first sample of the first output line of a frame.
- `eof_o`  out  1  last sample of the last output line of a frame.

## Operation
- Symbols: N = `CHANNEL_NUM*STRING_LEN` samples per input line; M = 2N samples per output line.
- State machine:
  - States are FILL, EMIT0 and EMIT1.
  - Reset state is FILL.
- FILL:
  - `ready_o` = 1.
  - Each accepted sample is written to buffer address `wr_cnt`, and `wr_cnt` increments.
  - If an accepted sample carries `sof_i`, the line's `sof_flag` is set.
  - If an accepted sample carries `eof_i`, the line's `eof_flag` is set.
  - When the accepted sample has `wr_cnt == N-1`, the state goes to EMIT0 and `wr_cnt` returns to 0.
  - `eop_i` is informational only; line length is defined by the count.
- Resync on `sop_i`:
  - An accepted `sop_i` with `wr_cnt != 0` discards the partial line.
  - That sample is written at address 0 and `wr_cnt` becomes 1.
  - `sof_flag` is reloaded from this sample's `sof_i`.
- EMIT0 and EMIT1:
  - `ready_o` = 0.
  - The read sequencer uses three nested counters: pixel `p` in 0..`STRING_LEN-1`, repeat `r` in 0..1, and channel `c` in 0..`CHANNEL_NUM-1`. The channel counter is innermost.
  - Read address = `p*CHANNEL_NUM + c`, formed with `$clog2(N)`-bit arithmetic.
  - One read is issued per cycle, with no gaps.
  - At the end of EMIT0 the state goes to EMIT1. At the end of EMIT1 the state goes to FILL.
  - `sof_flag` and `eof_flag` are cleared when the state leaves EMIT1.
- Flags on the output:
  - `sop_o` is asserted on the first sample of each EMIT pass.
  - `eop_o` is asserted on the last sample of each EMIT pass.
  - `sof_o` = `sop_o` of EMIT0 && `sof_flag`.
  - `eof_o` = `eop_o` of EMIT1 && `eof_flag`.
- Input while not ready: `valid_i` while `ready_o` = 0 is ignored; no write occurs and no counter changes.
- Reset:
  - Assertion of `reset` at any point (including mid-line or mid-emit) clears the state to FILL and clears all counters and flags.
  - All outputs are 0, and `ready_o` is forced to 0 while `reset` is high.
  - The buffer contents are not cleared.

## Timing
- `ready_o` is decoded from the state register.
- Suppose the last sample of a line is accepted at edge t:
  - `ready_o` is low from cycle t+1.
  - The first read address is issued in cycle t+1.
  - The buffer read is registered and all output flags are registered, so the first `data_valid_o` appears at cycle t+2.
- `data_valid_o` is high for 2M consecutive cycles, t+2 through t+2M+1.
- The last read is issued at cycle t+2M. `ready_o` returns high at cycle t+2M+1, coincident with the last output sample.
- Minimum line period is N + 2M cycles.
- A write in FILL never overlaps an outstanding read of the same line.
- All outputs are 0 in any cycle where `data_valid_o` = 0.
- Output strobes can appear only on a valid cycle: `sop_o`, `eop_o`, `sof_o` and `eof_o` are never high without `data_valid_o`.

## Test plan
- Basic expansion:
  - Configuration `CHANNEL_NUM=3`, `STRING_LEN=4`.
  - Stimulus: one line with pixels (1,2,3),(4,5,6),(7,8,9),(10,11,12), accepted at edges 0..11.
  - Expected output at cycles 13..36: 1,2,3,1,2,3,4,5,6,4,5,6,…,10,11,12,10,11,12.
  - The same 24 samples repeat at cycles 37..60.
  - `sop_o` at cycles 13 and 37; `eop_o` at cycles 36 and 60.
  - `ready_o` is low during cycles 12..59 and high again at cycle 60.
- Frame flags:
  - Stimulus: a frame of 2 lines, with `sof_i` on sample 0 of line 0 and `eof_i` on sample 11 of line 1.
  - Expected: `sof_o` exactly once, on the first output sample of line 0.
  - Expected: `eof_o` exactly once, on the 48th output sample of line 1.
- Backpressure:
  - Stimulus: hold `valid_i` = 1 continuously with incrementing data.
  - Expected: only the samples presented while `ready_o` = 1 are accepted.
  - Expected: the output sequence contains no skipped or duplicated input values.
- Sop resync:
  - Stimulus: send 5 samples, then a `sop_i` sample of value 100, then 11 more samples.
  - Expected: the first 5 samples are discarded.
  - Expected: the output line begins 100, followed by the next two samples, then that same group of three repeated.
- Reset mid-emit:
  - Stimulus: assert `reset` at output cycle 20 of the first scenario.
  - Expected: all outputs go to 0 immediately and `ready_o` = 0 while `reset` is high.
  - Expected: after release, `ready_o` = 1 and a fresh line is expanded correctly.
- Parameter sweep:
  - Stimulus: run the first scenario with `CHANNEL_NUM=1`, `STRING_LEN=2`.
  - Expected output: a,a,b,b,a,a,b,b.

Source files
------------

// File: rtl/upsample_2x.sv
// upsample_2x: nearest-neighbour 2x upsampler; buffers one channel-interleaved line
// and replays it twice, each pixel's channel group emitted twice per pass.
module upsample_2x #(
    parameter int DATA_WIDTH  = 8,
    parameter int CHANNEL_NUM = 3,
    parameter int STRING_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  sop_i,
    input  logic                  eop_i,
    input  logic                  sof_i,
    input  logic                  eof_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_valid_o,
    output logic                  sop_o,
    output logic                  eop_o,
    output logic                  sof_o,
    output logic                  eof_o
);
    localparam int N  = CHANNEL_NUM * STRING_LEN;
    localparam int AW = N > 1 ? $clog2(N) : 1;
    localparam int PW = STRING_LEN > 1 ? $clog2(STRING_LEN) : 1;
    localparam int CW = CHANNEL_NUM > 1 ? $clog2(CHANNEL_NUM) : 1;

    typedef enum logic [1:0] {FILL, EMIT0, EMIT1} state_t;
    state_t state, state_nx;

    logic [DATA_WIDTH-1:0] mem [N];
    logic [AW-1:0] wr_cnt, wr_addr, rd_addr;
    logic [PW-1:0] p;
    logic [CW-1:0] c;
    logic r, sof_flag, eof_flag;
    logic accept, resync, line_done, emit, c_last, first, last;
    logic unused_eop;

    // line length is defined purely by the sample count
    assign unused_eop = eop_i;
    assign ready_o    = state == FILL && !reset;
    assign accept     = valid_i && ready_o;
    assign resync     = sop_i && wr_cnt != '0;
    assign wr_addr    = resync ? '0 : wr_cnt;
    assign line_done  = accept && !resync && wr_cnt == AW'(N - 1);
    assign emit       = state != FILL;
    assign c_last     = c == CW'(CHANNEL_NUM - 1);
    assign first      = c == '0 && !r && p == '0;
    assign last       = c_last && r && p == PW'(STRING_LEN - 1);
    assign rd_addr    = AW'(p) * AW'(CHANNEL_NUM) + AW'(c);

    always_comb begin
        state_nx = state;
        if (state == FILL && line_done)
            state_nx = EMIT0;
        else if (state == EMIT0 && last)
            state_nx = EMIT1;
        else if (state == EMIT1 && last)
            state_nx = FILL;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset)
            state <= FILL;
        else
            state <= state_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt   <= '0;
            sof_flag <= 1'b0;
            eof_flag <= 1'b0;
            p        <= '0;
            r        <= 1'b0;
            c        <= '0;
        end else begin
            if (accept) begin
                wr_cnt   <= resync ? AW'(1) : line_done ? '0 : wr_cnt + 1'b1;
                sof_flag <= (resync ? 1'b0 : sof_flag) | sof_i;
                eof_flag <= eof_flag | eof_i;
            end
            if (state == EMIT1 && last) begin
                sof_flag <= 1'b0;
                eof_flag <= 1'b0;
            end
            // channel innermost, then repeat, then pixel
            if (emit) begin
                c <= c_last ? '0 : c + 1'b1;
                r <= r ^ c_last;
                if (c_last && r)
                    p <= last ? '0 : p + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_o       <= '0;
            data_valid_o <= 1'b0;
            sop_o        <= 1'b0;
            eop_o        <= 1'b0;
            sof_o        <= 1'b0;
            eof_o        <= 1'b0;
        end else begin
            data_o       <= emit ? mem[rd_addr] : '0;
            data_valid_o <= emit;
            sop_o        <= emit && first;
            eop_o        <= emit && last;
            sof_o        <= state == EMIT0 && first && sof_flag;
            eof_o        <= state == EMIT1 && last && eof_flag;
        end
    end

    always_ff @(posedge clk)
        if (accept)
            mem[wr_addr] <= data_i;
endmodule

// File: tb/tb_upsample_2x.sv
// tb_upsample_2x: scoreboard bench for upsample_2x with table-driven lines
// and hand-written sequences for timing, resync, backpressure and reset.
module tb_upsample_2x;
    localparam int CN = 3;
    localparam int SL = 4;
    localparam int N  = CN * SL;
    localparam int M  = 2 * N;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       sof;
        logic       eof;
    } out_t;

    typedef struct {
        logic [7:0] base;
        bit         sof_in;
        bit         eof_in;
        bit         exp_sof;
        bit         exp_eof;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid_i = 1'b0;
    logic [7:0] data_i = '0;
    logic       sop_i = 1'b0, eop_i = 1'b0, sof_i = 1'b0, eof_i = 1'b0;
    logic       ready_o, data_valid_o, sop_o, eop_o, sof_o, eof_o;
    logic [7:0] data_o;

    logic       s_valid = 1'b0, s_sop = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_ready, s_dv, s_sop_o, s_eop_o, s_sof_o, s_eof_o;
    logic [7:0] s_dout;

    int   tests = 0;
    int   fails = 0;
    int   popped = 0;
    out_t exp_q[$];

    always #5 clk = ~clk;

    upsample_2x #(.DATA_WIDTH(8), .CHANNEL_NUM(CN), .STRING_LEN(SL)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .data_i(data_i),
        .sop_i(sop_i), .eop_i(eop_i), .sof_i(sof_i), .eof_i(eof_i),
        .ready_o(ready_o), .data_o(data_o), .data_valid_o(data_valid_o),
        .sop_o(sop_o), .eop_o(eop_o), .sof_o(sof_o), .eof_o(eof_o)
    );

    upsample_2x #(.DATA_WIDTH(8), .CHANNEL_NUM(1), .STRING_LEN(2)) dut_small (
        .clk(clk), .reset(reset), .valid_i(s_valid), .data_i(s_data),
        .sop_i(s_sop), .eop_i(1'b0), .sof_i(1'b0), .eof_i(1'b0),
        .ready_o(s_ready), .data_o(s_dout), .data_valid_o(s_dv),
        .sop_o(s_sop_o), .eop_o(s_eop_o), .sof_o(s_sof_o), .eof_o(s_eof_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        out_t e;
        if (!reset) begin
            if (!data_valid_o)
                check("idle_outputs_zero", {data_o, sop_o, eop_o, sof_o, eof_o}, 0);
            else if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got data %0d with nothing expected", data_o);
            end else begin
                e = exp_q.pop_front();
                popped++;
                check("out{data,sop,eop,sof,eof}", {data_o, sop_o, eop_o, sof_o, eof_o}, e);
            end
        end
    end

    task automatic push_line(input logic [7:0] px [N], input bit sf, input bit ef);
        for (int pass = 0; pass < 2; pass++)
            for (int k = 0; k < M; k++) begin
                out_t e;
                e.data = px[(k / (2 * CN)) * CN + k % CN];
                e.sop  = k == 0;
                e.eop  = k == M - 1;
                e.sof  = pass == 0 && k == 0 && sf;
                e.eof  = pass == 1 && k == M - 1 && ef;
                exp_q.push_back(e);
            end
    endtask

    task automatic send(input logic [7:0] d, input bit sp, input bit ep, input bit sf, input bit ef);
        int t = 0;
        while (!ready_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!ready_o) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: ready_o got 0, expected 1");
        end
        valid_i = 1'b1; data_i = d; sop_i = sp; eop_i = ep; sof_i = sf; eof_i = ef;
        @(negedge clk);
        valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;
    endtask

    task automatic send_line(input logic [7:0] base, input bit sf, input bit ef,
                             input bit exp_sf, input bit exp_ef);
        logic [7:0] px [N];
        for (int i = 0; i < N; i++) begin
            px[i] = base + 8'(i);
            send(px[i], i == 0, i == N - 1, sf && i == 0, ef && i == N - 1);
        end
        push_line(px, exp_sf, exp_ef);
    endtask

    task automatic drain;
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic small_test;
        logic [7:0] exp_s [8];
        int t = 0;
        exp_s = '{8'd7, 8'd7, 8'd9, 8'd9, 8'd7, 8'd7, 8'd9, 8'd9};
        check("small_ready", s_ready, 1);
        s_valid = 1'b1; s_data = 8'd7; s_sop = 1'b1;
        @(negedge clk);
        s_data = 8'd9; s_sop = 1'b0;
        @(negedge clk);
        s_valid = 1'b0;
        while (!s_dv && t < 20) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 8; i++) begin
            check("small_valid_data", {s_dv, s_dout}, {1'b1, exp_s[i]});
            check("small_sop_eop", {s_sop_o, s_eop_o}, {i == 0 || i == 4, i == 3 || i == 7});
            @(negedge clk);
        end
        check("small_idle", {s_dv, s_dout, s_sof_o, s_eof_o}, 0);
    endtask

    task automatic backpressure;
        logic [7:0] px [N];
        logic [7:0] v = 8'd150;
        int acc = 0, lines = 0, t = 0;
        valid_i = 1'b1;
        while (lines < 2 && t < 1000) begin
            data_i = v;
            sop_i  = acc == 0;
            if (ready_o) begin
                px[acc] = v;
                acc++;
                if (acc == N) begin
                    push_line(px, 1'b0, 1'b0);
                    acc = 0;
                    lines++;
                end
            end
            v++;
            t++;
            @(negedge clk);
        end
        valid_i = 1'b0; sop_i = 1'b0;
        check("bp_lines_accepted", lines, 2);
        drain;
    endtask

    task automatic reset_mid_emit;
        int start, t = 0;
        send_line(8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        start = popped;
        while (popped < start + 20 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("rst_reached_out20", popped - start >= 20, 1);
        #2 reset = 1'b1;
        exp_q.delete();
        #1;
        check("rst_async_out", {data_valid_o, sop_o, eop_o, sof_o, eof_o, data_o}, 0);
        check("rst_async_ready", ready_o, 0);
        repeat (3) begin
            @(negedge clk);
            check("rst_hold_out", {data_valid_o, sop_o, eop_o, sof_o, eof_o, data_o}, 0);
            check("rst_hold_ready", ready_o, 0);
        end
        #2 reset = 1'b0;
        @(negedge clk);
        check("rst_rel_ready", ready_o, 1);
        check("rst_rel_out", {data_valid_o, data_o}, 0);
        send_line(8'd33, 1'b1, 1'b1, 1'b1, 1'b1);
        drain;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt [4];
        vt[0] = '{8'd20, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[1] = '{8'd40, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[2] = '{8'd60, 1'b1, 1'b1, 1'b1, 1'b1};
        vt[3] = '{8'd200, 1'b0, 1'b0, 1'b0, 1'b0};
        repeat (2) @(negedge clk);
        check("rst_ready", ready_o, 0);
        check("rst_out", {data_valid_o, sop_o, eop_o, sof_o, eof_o, data_o}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", ready_o, 1);
        small_test;
        // basic expansion with cycle-exact latency and ready window
        send_line(8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lat_ready_low", ready_o, 0);
        check("lat_no_valid_yet", data_valid_o, 0);
        for (int i = 0; i < 2 * M; i++) begin
            @(negedge clk);
            check("valid_run", data_valid_o, 1);
            check("ready_run", ready_o, i == 2 * M - 1);
        end
        @(negedge clk);
        check("valid_end", data_valid_o, 0);
        check("ready_end", ready_o, 1);
        for (int i = 0; i < 4; i++)
            send_line(vt[i].base, vt[i].sof_in, vt[i].eof_in, vt[i].exp_sof, vt[i].exp_eof);
        drain;
        // partial line with sof is discarded by a resync; its sof must not leak
        send(8'd50, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < 5; i++)
            send(8'(50 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        send_line(8'd100, 1'b0, 1'b0, 1'b0, 1'b0);
        drain;
        backpressure;
        reset_mid_emit;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
